pdp_mem_arbiter: RTL and testbench
==================================

PDP_MEM_ARBITER -- requirements
Module: pdp_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, memory address width.
REQ-002 Parameter DATA_WIDTH, default 12, memory word width.
REQ-003 Parameter TIMEOUT, default 15, maximum cycles to wait for mem_rvalid (range 1..255).
REQ-004 Parameter FAIR_MAX, default 3, maximum consecutive exec grants while ifu is pending.
REQ-005 clk  in  1  single system clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 ifu_rd_req  in  1  fetch-read request; level, held until ifu_rd_ack.
REQ-008 ifu_rd_addr  in  ADDR_WIDTH  fetch address.
REQ-009 ifu_rd_data  out  DATA_WIDTH  fetch read data, valid with ifu_rd_ack.
REQ-010 ifu_rd_ack  out  1  one-cycle completion pulse for the fetch read.
REQ-011 exec_rd_req / exec_rd_addr  in  1 / ADDR_WIDTH  operand-read request and address; level, held until exec_rd_ack.
REQ-012 exec_rd_data / exec_rd_ack  out  DATA_WIDTH / 1  operand-read data and one-cycle completion pulse.
REQ-013 exec_wr_req / exec_wr_addr / exec_wr_data  in  1 / ADDR_WIDTH / DATA_WIDTH  write request, address and data; held until exec_wr_ack.
REQ-014 exec_wr_ack  out  1  one-cycle write-completion pulse.
REQ-015 mem_req / mem_we  out  1 / 1  one-cycle memory command strobe and write enable.
REQ-016 mem_addr / mem_wdata  out  ADDR_WIDTH / DATA_WIDTH  memory command address and write data.
REQ-017 mem_rdata / mem_rvalid  in  DATA_WIDTH / 1  memory read return data and its valid strobe.
REQ-018 busy  out  1  high whenever the FSM is not IDLE.
REQ-019 timeout_err  out  1  sticky flag, set on any read timeout.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT_RD, DONE; all outputs are registered.
REQ-021 IDLE: if any request is pending, latch the winner's port ID, address and data, then go to ISSUE.
REQ-022 Priority: exec_wr > exec_rd > ifu_rd, except that ifu_rd wins when fair_cnt == FAIR_MAX and ifu_rd_req is high.
REQ-023 fair_cnt increments on each exec grant while ifu_rd_req is high, saturates at FAIR_MAX, and clears on any ifu grant.
REQ-024 ISSUE: drive mem_req=1 for exactly one cycle with the latched address, data and mem_we; writes then go to DONE and reads go to WAIT_RD.
REQ-025 WAIT_RD: on mem_rvalid, capture mem_rdata into the granted port's data register and go to DONE.
REQ-026 WAIT_RD: a cycle counter starts at 0 on entry; if it reaches TIMEOUT without mem_rvalid, load data 0, set timeout_err, and go to DONE.
REQ-027 DONE: pulse exactly one ack for the granted port for one cycle, then return to IDLE; no new grant is made in DONE.
REQ-028 Latency: write request seen in IDLE -> ack 3 cycles later; read with rvalid k cycles after mem_req (k>=1) -> ack k+2 cycles after mem_req.
REQ-029 Each read-data output holds its value until that port's next read completes.
REQ-030 mem_rvalid outside WAIT_RD is ignored, with no state or data change.
REQ-031 A request dropped after grant does not abort the transaction; the ack still pulses.
REQ-032 Simultaneous requests on all three ports: exactly one is granted per transaction, and the others remain pending.
REQ-033 Idle memory outputs are mem_req=0 and mem_we=0, with mem_addr and mem_wdata holding their last values.

Reset
REQ-034 Reset asserted at any time forces IDLE immediately and zeroes all outputs, fair_cnt, the timeout counter and timeout_err.
REQ-035 Reset mid-transaction produces no ack for that transaction; a late mem_rvalid after reset is ignored per REQ-030.
REQ-036 The first grant is evaluated on the first rising edge after reset deasserts.

Verification
REQ-037 Write 0o7777 to 0o0200: mem_req=1 with mem_we=1, mem_addr=0o0200, mem_wdata=0o7777 one cycle after request; exec_wr_ack 3 cycles after request.
REQ-038 ifu_rd_req and exec_rd_req together, rvalid 2 cycles after mem_req with 0o1234: exec served first with exec_rd_data=0o1234, then ifu served.
REQ-039 exec_wr_req held continuously with ifu_rd_req high: ifu is granted after exactly 3 exec grants, and fair_cnt returns to 0.
REQ-040 Read with no mem_rvalid: ack 15 cycles after entering WAIT_RD with data 0; timeout_err=1 and stays 1.
REQ-041 reset pulse during WAIT_RD, then mem_rvalid: no ack, busy=0, and all outputs read 0.
REQ-042 mem_rvalid pulsed while IDLE: no ack, and both read-data outputs are unchanged.

Source files
------------

// File: rtl/pdp_mem_arbiter.sv
// Three-port memory arbiter: instruction fetch, execute read and execute write share
// one memory port through a four-state FSM with fairness and read timeout.
module pdp_mem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int TIMEOUT    = 15,
  parameter int FAIR_MAX   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  ifu_rd_ack,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_rd_ack,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  exec_wr_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int FAIR_W = (FAIR_MAX < 1) ? 1 : $clog2(FAIR_MAX + 1);
  localparam int TMO_W  = 8;
  localparam logic [FAIR_W-1:0] FAIR_TOP = FAIR_W'(FAIR_MAX);
  // WAIT_RD lasts TIMEOUT-1 cycles so the timeout ack lands TIMEOUT cycles after entry
  localparam logic [TMO_W-1:0]  TMO_LAST = (TIMEOUT > 1) ? TMO_W'(TIMEOUT - 2) : '0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;
  typedef enum logic [1:0] {PORT_IFU, PORT_EXEC_RD, PORT_EXEC_WR} port_t;

  state_t state, state_nxt;
  port_t  port_q, port_nxt, win_port;

  logic [ADDR_WIDTH-1:0] win_addr;
  logic [FAIR_W-1:0]     fair_cnt, fair_nxt;
  logic [TMO_W-1:0]      tmo_cnt, tmo_nxt;
  logic                  any_req, ack_any;

  logic                  mem_req_nxt, mem_we_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_wdata_nxt;
  logic [DATA_WIDTH-1:0] ifu_rd_data_nxt, exec_rd_data_nxt;
  logic                  ifu_rd_ack_nxt, exec_rd_ack_nxt, exec_wr_ack_nxt;
  logic                  busy_nxt, timeout_err_nxt;

  assign any_req = ifu_rd_req | exec_rd_req | exec_wr_req;
  // Requesters still hold their level during the ack cycle, so no grant is made then
  assign ack_any = ifu_rd_ack | exec_rd_ack | exec_wr_ack;

  always_comb begin
    win_port = PORT_IFU;
    win_addr = ifu_rd_addr;
    if (ifu_rd_req && (fair_cnt == FAIR_TOP)) begin
      win_port = PORT_IFU;
      win_addr = ifu_rd_addr;
    end else if (exec_wr_req) begin
      win_port = PORT_EXEC_WR;
      win_addr = exec_wr_addr;
    end else if (exec_rd_req) begin
      win_port = PORT_EXEC_RD;
      win_addr = exec_rd_addr;
    end
  end

  always_comb begin
    state_nxt        = state;
    port_nxt         = port_q;
    fair_nxt         = fair_cnt;
    tmo_nxt          = tmo_cnt;
    mem_req_nxt      = 1'b0;
    mem_we_nxt       = 1'b0;
    mem_addr_nxt     = mem_addr;
    mem_wdata_nxt    = mem_wdata;
    ifu_rd_data_nxt  = ifu_rd_data;
    exec_rd_data_nxt = exec_rd_data;
    ifu_rd_ack_nxt   = 1'b0;
    exec_rd_ack_nxt  = 1'b0;
    exec_wr_ack_nxt  = 1'b0;
    timeout_err_nxt  = timeout_err;

    unique case (state)
      IDLE: begin
        if (any_req && !ack_any) begin
          state_nxt    = ISSUE;
          port_nxt     = win_port;
          tmo_nxt      = '0;
          mem_req_nxt  = 1'b1;
          mem_we_nxt   = (win_port == PORT_EXEC_WR);
          mem_addr_nxt = win_addr;
          if (win_port == PORT_EXEC_WR) mem_wdata_nxt = exec_wr_data;
          if (win_port == PORT_IFU) begin
            fair_nxt = '0;
          end else if (ifu_rd_req && (fair_cnt != FAIR_TOP)) begin
            fair_nxt = fair_cnt + 1'b1;
          end
        end
      end
      ISSUE: begin
        tmo_nxt   = '0;
        state_nxt = (port_q == PORT_EXEC_WR) ? DONE : WAIT_RD;
      end
      WAIT_RD: begin
        if (mem_rvalid) begin
          state_nxt = DONE;
          if (port_q == PORT_IFU) ifu_rd_data_nxt  = mem_rdata;
          else                    exec_rd_data_nxt = mem_rdata;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt       = DONE;
          timeout_err_nxt = 1'b1;
          if (port_q == PORT_IFU) ifu_rd_data_nxt  = '0;
          else                    exec_rd_data_nxt = '0;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        case (port_q)
          PORT_IFU:     ifu_rd_ack_nxt  = 1'b1;
          PORT_EXEC_RD: exec_rd_ack_nxt = 1'b1;
          PORT_EXEC_WR: exec_wr_ack_nxt = 1'b1;
          default:      ifu_rd_ack_nxt  = 1'b0;
        endcase
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Registered outputs and bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_q       <= PORT_IFU;
      fair_cnt     <= '0;
      tmo_cnt      <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      ifu_rd_data  <= '0;
      exec_rd_data <= '0;
      ifu_rd_ack   <= 1'b0;
      exec_rd_ack  <= 1'b0;
      exec_wr_ack  <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      port_q       <= port_nxt;
      fair_cnt     <= fair_nxt;
      tmo_cnt      <= tmo_nxt;
      mem_req      <= mem_req_nxt;
      mem_we       <= mem_we_nxt;
      mem_addr     <= mem_addr_nxt;
      mem_wdata    <= mem_wdata_nxt;
      ifu_rd_data  <= ifu_rd_data_nxt;
      exec_rd_data <= exec_rd_data_nxt;
      ifu_rd_ack   <= ifu_rd_ack_nxt;
      exec_rd_ack  <= exec_rd_ack_nxt;
      exec_wr_ack  <= exec_wr_ack_nxt;
      busy         <= busy_nxt;
      timeout_err  <= timeout_err_nxt;
    end
  end

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// Bench for pdp_mem_arbiter: scoreboard of expected acks (port, data, latency)
// plus a behavioural memory with programmable read latency.
module tb_pdp_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 12;
  localparam int TMO = 15;
  localparam int FMAX = 3;
  localparam int P_IFU = 0;
  localparam int P_RD = 1;
  localparam int P_WR = 2;

  logic          clk, reset;
  logic          ifu_rd_req, exec_rd_req, exec_wr_req;
  logic [AW-1:0] ifu_rd_addr, exec_rd_addr, exec_wr_addr;
  logic [DW-1:0] exec_wr_data;
  logic [DW-1:0] ifu_rd_data, exec_rd_data;
  logic          ifu_rd_ack, exec_rd_ack, exec_wr_ack;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_rvalid, busy, timeout_err;

  pdp_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO), .FAIR_MAX(FMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr),
    .ifu_rd_data(ifu_rd_data), .ifu_rd_ack(ifu_rd_ack),
    .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr),
    .exec_rd_data(exec_rd_data), .exec_rd_ack(exec_rd_ack),
    .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr),
    .exec_wr_data(exec_wr_data), .exec_wr_ack(exec_wr_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mem_arr [0:(1<<AW)-1];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  int            rd_lat = 1;
  int            req_cyc = 0;
  logic          inject = 1'b0;
  logic          hold_wr = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic push(input int port, input logic [DW-1:0] data, input int lat);
    exp_t e;
    e.port = port;
    e.data = data;
    e.lat  = lat;
    sb.push_back(e);
  endtask

  // Wait for the scoreboard to empty, releasing each request once its ack shows
  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      if (ifu_rd_ack) ifu_rd_req = 1'b0;
      if (exec_rd_ack) exec_rd_req = 1'b0;
      if (exec_wr_ack && !hold_wr) exec_wr_req = 1'b0;
      n++;
    end while (sb.size() > 0 && n < max_cyc);
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  function automatic int ack_port(input logic [2:0] a);
    if (a[2]) return P_WR;
    if (a[1]) return P_RD;
    return P_IFU;
  endfunction

  // Memory model: writes land in mem_arr, reads answer rd_lat cycles after mem_req
  initial begin
    int            rv_cnt;
    logic [DW-1:0] rv_data;
    rv_cnt = 0;
    rv_data = '0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < (1 << AW); i++) mem_arr[i] = '0;
    mem_arr[12'o0010] = 12'o4321;
    mem_arr[12'o0300] = 12'o1234;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rv_data;
        end
      end
      if (inject) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 12'o5555;
      end
      if (mem_req) begin
        if (mem_we) mem_arr[mem_addr] = mem_wdata;
        else if (rd_lat > 0) begin
          rv_cnt  = rd_lat;
          rv_data = mem_arr[mem_addr];
        end
      end
    end
  end

  // Ack monitor against the scoreboard
  initial begin
    logic [2:0] acks;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (mem_req) req_cyc = cyc;
      acks = {exec_wr_ack, exec_rd_ack, ifu_rd_ack};
      if (acks != 3'b000) begin
        chk("single_ack", $countones(acks), 1);
        if (sb.size() == 0) begin
          chk("unexpected_ack", {29'd0, acks}, 0);
        end else begin
          e = sb.pop_front();
          chk("ack_port", ack_port(acks), e.port);
          chk("ack_latency", cyc - req_cyc, e.lat);
          if (e.port == P_IFU) chk("ifu_rd_data", {20'd0, ifu_rd_data}, {20'd0, e.data});
          else if (e.port == P_RD) chk("exec_rd_data", {20'd0, exec_rd_data}, {20'd0, e.data});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ifu_rd_req = 1'b0;  exec_rd_req = 1'b0;  exec_wr_req = 1'b0;
    ifu_rd_addr = '0;   exec_rd_addr = '0;   exec_wr_addr = '0;
    exec_wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_read_data", {ifu_rd_data, exec_rd_data}, 0);
    chk("rst_acks", {ifu_rd_ack, exec_rd_ack, exec_wr_ack}, 0);
    chk("rst_timeout_err", timeout_err, 0);

    // Write straight out of reset: command one cycle later, ack three cycles later
    reset = 1'b0;
    exec_wr_req = 1'b1;  exec_wr_addr = 12'o0200;  exec_wr_data = 12'o7777;
    push(P_WR, '0, 2);
    @(negedge clk);
    chk("wr_mem_req", mem_req, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 12'o0200);
    chk("wr_mem_wdata", mem_wdata, 12'o7777);
    chk("wr_busy", busy, 1);
    @(negedge clk);
    chk("wr_ack_early", exec_wr_ack, 0);
    chk("wr_mem_req_pulse", mem_req, 0);
    chk("wr_mem_addr_hold", mem_addr, 12'o0200);
    @(negedge clk);
    chk("wr_ack", exec_wr_ack, 1);
    exec_wr_req = 1'b0;
    @(negedge clk);
    chk("wr_ack_pulse", exec_wr_ack, 0);
    repeat (2) @(negedge clk);

    // Fetch and operand read together: exec first, then fetch
    rd_lat = 2;
    ifu_rd_addr = 12'o0010;  exec_rd_addr = 12'o0300;
    ifu_rd_req = 1'b1;  exec_rd_req = 1'b1;
    push(P_RD, 12'o1234, 4);
    push(P_IFU, 12'o4321, 4);
    drain(80);
    chk("pair_exec_data", exec_rd_data, 12'o1234);
    chk("pair_ifu_data", ifu_rd_data, 12'o4321);
    chk("pair_no_timeout", timeout_err, 0);

    // Read back the earlier write
    rd_lat = 1;
    exec_rd_addr = 12'o0200;  exec_rd_req = 1'b1;
    push(P_RD, 12'o7777, 3);
    drain(40);

    // No rvalid at all: timeout returns zero data
    rd_lat = 0;
    exec_rd_addr = 12'o0500;  exec_rd_req = 1'b1;
    push(P_RD, '0, TMO + 1);
    drain(80);
    chk("to_err", timeout_err, 1);
    chk("to_data", exec_rd_data, 0);
    chk("to_ifu_data_kept", ifu_rd_data, 12'o4321);

    // Continuous writes against a pending fetch, twice to show the counter clears
    rd_lat = 1;
    for (int r = 0; r < 2; r++) begin
      hold_wr = 1'b1;
      exec_wr_addr = 12'o0400;  exec_wr_data = DW'(12'o1111 + r);
      ifu_rd_addr = 12'o0010;
      exec_wr_req = 1'b1;  ifu_rd_req = 1'b1;
      for (int k = 0; k < FMAX; k++) push(P_WR, '0, 2);
      push(P_IFU, 12'o4321, 3);
      drain(120);
      exec_wr_req = 1'b0;
      hold_wr = 1'b0;
      repeat (3) @(negedge clk);
    end
    chk("to_err_sticky", timeout_err, 1);

    // Stray rvalid while idle must not touch anything
    inject = 1'b1;
    repeat (2) @(negedge clk);
    inject = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_rv_ifu_data", ifu_rd_data, 12'o4321);
    chk("idle_rv_exec_data", exec_rd_data, 0);
    chk("idle_rv_busy", busy, 0);

    // Reset in the middle of a read, with the memory answering afterwards
    rd_lat = 5;
    ifu_rd_addr = 12'o0010;  ifu_rd_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("rm_busy_before", busy, 1);
    reset = 1'b1;
    ifu_rd_req = 1'b0;
    #1;
    chk("rm_busy", busy, 0);
    chk("rm_read_data", {ifu_rd_data, exec_rd_data}, 0);
    chk("rm_timeout_err", timeout_err, 0);
    chk("rm_mem_cmd", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rm_busy_after", busy, 0);
    chk("rm_ifu_data_after", ifu_rd_data, 0);
    chk("rm_acks_after", {ifu_rd_ack, exec_rd_ack, exec_wr_ack}, 0);
    chk("rm_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
